alu_sequencer: RTL
==================

# alu_sequencer

Multi-cycle control sequencer that issues work to the combinational ALU in the accumulator datapath. It accepts one 9-bit instruction at a time over a valid/ready handshake and reads the operand from the register file. It drives the ALU operation code and operands, then commits the result to the internal accumulator or back to the register file. It sits between instruction fetch and the ALU/register file, and also raises branch requests to fetch.

## Interface
- DW, 8, datapath width; ALU operand/result width.
- REG_AW, 4, register-file address width; must be ≤ 4 (instruction field width).

- clk  in  1  clock; all state changes on rising edge.
- rst_n  in  1  reset; synchronous, active-low.
- instr_valid  in  1  instruction word present.
- instr_ready  out  1  sequencer can accept an instruction.
- instr  in  9  instruction word.
- rf_raddr  out  REG_AW  register-file read address.
- rf_rdata  in  DW  read data; valid one cycle after rf_raddr.
- rf_we  out  1  register-file write strobe (1-cycle pulse).
- rf_waddr  out  REG_AW  write address.
- rf_wdata  out  DW  write data.
- alu_op  out  3  ALU op code: Add=0, Sub=1, Sll=2, Srl=3, Equ=4, Gtr=5, And=6, Xor=7.
- alu_reg  out  DW  ALU register operand (= rf_rdata).
- alu_acc  out  DW  ALU accumulator operand (= acc_out).
- alu_rslt  in  DW  ALU result (combinational).
- acc_out  out  DW  accumulator value.
- done  out  1  1-cycle pulse at instruction retirement.
- branch_taken  out  1  1-cycle pulse: branch request.
- branch_tgt  out  6  branch target, valid with branch_taken.
- perf_count  out  16  retired-instruction count (see Configuration).

## Operation
- Encoding, instr[8]=0 (ALU class):
  - [7:5] alu_op.
  - [4] destination: 0 = accumulator, 1 = register.
  - [3:0] register address.
- Encoding, instr[8]=1 (misc class), sub-op in [7:6]:
  - 00 LDA: acc ← reg[[3:0]].
  - 01 STA: reg[[3:0]] ← acc.
  - 10 BNZ: branch to [5:0] if acc ≠ 0.
  - 11 LDI: acc ← zero-extended [5:0].
- FSM states IDLE → READ → EXEC → WB → IDLE. Every instruction visits all four states; there are no early exits.
  - IDLE: instr_ready=1. On instr_valid & instr_ready, capture instr and go to READ. Otherwise stay in IDLE.
  - READ: drive rf_raddr from the captured address field.
  - EXEC: rf_rdata is valid. Drive alu_op/alu_reg/alu_acc and capture the selected result on the EXEC→WB edge.
  - WB: commit. Pulse done; pulse rf_we for register destinations or STA; pulse branch_taken if BNZ and acc ≠ 0.
- Arithmetic belongs to the ALU. The result is DW bits, with Sub = reg − acc mod 2^DW, Equ/Gtr ∈ {0,1}, and shift amounts ≥ DW giving 0. The sequencer never alters alu_rslt.
- Misc-class instructions bypass the ALU result. alu_op is driven Add (0) during their EXEC state.
- BNZ tests the accumulator value at EXEC. The accumulator is unchanged by BNZ and STA, and by ALU instructions with a register destination.
- instr_valid outside IDLE is ignored. The source must hold instr stable until it is accepted.
- Reset mid-operation: the in-flight instruction is discarded. No rf_we, done or branch_taken pulses are issued for it.

## Timing
- Reset values: state IDLE, instr_ready=1, acc_out=0, rf_we=0, done=0, branch_taken=0, rf_raddr=0, rf_waddr=0, rf_wdata=0, branch_tgt=0, perf_count=0.
- Accept at cycle T. Then READ at T+1, EXEC at T+2, WB at T+3 (done, rf_we, branch_taken high), IDLE at T+4.
- Latency is 3 cycles from accept to done. Throughput is one instruction per 4 cycles.
- acc_out shows the new value from T+3.
- A WB write is committed before the next READ, so there is no read-after-write hazard.
- rf_we, done and branch_taken are registered, never high for more than one cycle, and never high outside WB.

## Configuration
- ALU_SEQ_PERF_EN defined: perf_count increments by 1 at each done pulse and wraps 0xFFFF→0x0000. It clears on reset.
- Not defined: no counter logic is built and perf_count is tied to 0.

## Structure
- The shared definitions package already holds the ALU_Ops enum. Add to it:
  - Seq_State enum (IDLE, READ, EXEC, WB).
  - Misc_Ops enum (LDA, STA, BNZ, LDI).
  - Instruction field position constants.
- One combinational sub-module, seq_decode. It maps the captured instr to alu_op, destination select, register address, misc sub-op and immediate.
- The FSM, accumulator and output registers stay in alu_sequencer.

## Test plan
- Reset: hold rst_n=0 for 2 cycles → instr_ready=1, acc_out=0x00, rf_we=done=branch_taken=0, perf_count=0.
- LDI: instr=0x1EA accepted at T → done at T+3 only; acc_out=0x2A from T+3; instr_ready=1 at T+4.
- ALU to register: reg[3]=0x05, acc=0x2A, instr=0x013 (Add, dest reg, addr 3) → rf_raddr=3 at T+1; rf_we pulse at T+3 with waddr=3, wdata=0x2F; acc_out stays 0x2A.
- Wrap: acc=0x01, reg[2]=0x00, instr=0x022 (Sub, dest acc) → acc_out=0xFF at T+3; instr_valid held high during busy cycles does not trigger a second acceptance.
- BNZ: instr=0x195 with acc=0x00 → no branch_taken. With acc=0x01 → branch_taken pulse at T+3 with branch_tgt=0x15; acc unchanged.
- Reset mid-op: drop rst_n during EXEC of 0x013 → no rf_we, no done, acc_out=0, IDLE next cycle. With ALU_SEQ_PERF_EN, three retirements → perf_count=3.

Source files
------------

// File: rtl/alu_sequencer_pkg.sv
// Shared definitions for the accumulator-datapath sequencer: op enums, FSM states, instruction fields.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package alu_sequencer_pkg;

    // ALU operation codes driven on alu_op.
    typedef enum logic [2:0] {
        OP_ADD = 3'd0,
        OP_SUB = 3'd1,
        OP_SLL = 3'd2,
        OP_SRL = 3'd3,
        OP_EQU = 3'd4,
        OP_GTR = 3'd5,
        OP_AND = 3'd6,
        OP_XOR = 3'd7
    } alu_op_e;

    // Sequencer FSM; every instruction walks all four states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        EXEC = 2'd2,
        WB   = 2'd3
    } seq_state_e;

    // Misc-class sub-operations, instr[7:6] when instr[8]=1.
    typedef enum logic [1:0] {
        MISC_LDA = 2'd0,
        MISC_STA = 2'd1,
        MISC_BNZ = 2'd2,
        MISC_LDI = 2'd3
    } misc_op_e;

    // Instruction field positions.
    localparam int INSTR_W   = 9;
    localparam int CLASS_BIT = 8;
    localparam int OP_MSB    = 7;
    localparam int OP_LSB    = 5;
    localparam int DEST_BIT  = 4;
    localparam int MISC_MSB  = 7;
    localparam int MISC_LSB  = 6;
    localparam int IMM_MSB   = 5;
    localparam int IMM_LSB   = 0;
    localparam int IMM_W     = IMM_MSB - IMM_LSB + 1;
    localparam int PERF_W    = 16;

endpackage

// File: rtl/alu_sequencer_if.sv
// Bundle of instruction handshake, register-file and ALU signals around the sequencer.
// Latency: n/a (wires only).
// Backpressure: instr_valid/instr_ready; source holds instr until accepted.
// master = sequencer view, slave = fetch/register-file/ALU view.
interface alu_sequencer_if #(
    parameter int DW     = 8,
    parameter int REG_AW = 4
);
    import alu_sequencer_pkg::*;

    logic                instr_valid;
    logic                instr_ready;
    logic [INSTR_W-1:0]  instr;
    logic [REG_AW-1:0]   rf_raddr;
    logic [DW-1:0]       rf_rdata;
    logic                rf_we;
    logic [REG_AW-1:0]   rf_waddr;
    logic [DW-1:0]       rf_wdata;
    alu_op_e             alu_op;
    logic [DW-1:0]       alu_reg;
    logic [DW-1:0]       alu_acc;
    logic [DW-1:0]       alu_rslt;

    modport master (
        input  instr_valid, instr, rf_rdata, alu_rslt,
        output instr_ready, rf_raddr, rf_we, rf_waddr, rf_wdata, alu_op, alu_reg, alu_acc
    );

    modport slave (
        output instr_valid, instr, rf_rdata, alu_rslt,
        input  instr_ready, rf_raddr, rf_we, rf_waddr, rf_wdata, alu_op, alu_reg, alu_acc
    );

endinterface

// File: rtl/alu_sequencer_seq_decode.sv
// Combinational decode of the captured instruction word into its fields.
// Latency: 0 cycles (pure combinational).
// Backpressure: none.
// Ports: instr in; is_misc, alu_op, dest_reg, reg_addr, misc_op, imm out.
module seq_decode
    import alu_sequencer_pkg::*;
#(
    parameter int REG_AW = 4
) (
    input  logic [INSTR_W-1:0] instr,
    output logic               is_misc,
    output alu_op_e            alu_op,
    output logic               dest_reg,
    output logic [REG_AW-1:0]  reg_addr,
    output misc_op_e           misc_op,
    output logic [IMM_W-1:0]   imm
);

    always_comb begin
        is_misc  = instr[CLASS_BIT];
        // Misc-class words reuse bits [7:5] for other fields, so the ALU sees Add for them.
        alu_op   = is_misc ? OP_ADD : alu_op_e'(instr[OP_MSB:OP_LSB]);
        dest_reg = instr[DEST_BIT];
        reg_addr = instr[REG_AW-1:0];
        misc_op  = misc_op_e'(instr[MISC_MSB:MISC_LSB]);
        imm      = instr[IMM_MSB:IMM_LSB];
    end

endmodule

// File: rtl/alu_sequencer.sv
// Four-state sequencer issuing one instruction to the ALU / register file and committing the result.
// Latency: 3 cycles accept-to-done; one instruction per 4 cycles.
// Backpressure: instr_ready only in IDLE; instr_valid in other states is ignored.
// Ports: clk, rst_n (sync active-low), bus (alu_sequencer_if.master), acc_out, done,
//        branch_taken, branch_tgt, perf_count. Optional counter: define ALU_SEQ_PERF_EN.
module alu_sequencer
    import alu_sequencer_pkg::*;
#(
    parameter int DW     = 8,
    parameter int REG_AW = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    alu_sequencer_if.master    bus,
    output logic [DW-1:0]      acc_out,
    output logic               done,
    output logic               branch_taken,
    output logic [IMM_W-1:0]   branch_tgt,
    output logic [PERF_W-1:0]  perf_count
);

    seq_state_e          state_q, state_d;
    logic [INSTR_W-1:0]  instr_q, instr_d;
    logic [DW-1:0]       acc_q, acc_d;
    logic                rf_we_q, rf_we_d;
    logic [REG_AW-1:0]   rf_waddr_q, rf_waddr_d;
    logic [DW-1:0]       rf_wdata_q, rf_wdata_d;
    logic                done_q, done_d;
    logic                branch_q, branch_d;
    logic [IMM_W-1:0]    tgt_q, tgt_d;

    logic                ready_c;
    alu_op_e             alu_op_c;

    logic                dec_is_misc;
    alu_op_e             dec_alu_op;
    logic                dec_dest_reg;
    logic [REG_AW-1:0]   dec_reg_addr;
    misc_op_e            dec_misc_op;
    logic [IMM_W-1:0]    dec_imm;

    seq_decode #(.REG_AW(REG_AW)) u_decode (
        .instr    (instr_q),
        .is_misc  (dec_is_misc),
        .alu_op   (dec_alu_op),
        .dest_reg (dec_dest_reg),
        .reg_addr (dec_reg_addr),
        .misc_op  (dec_misc_op),
        .imm      (dec_imm)
    );

    always_comb begin
        state_d    = state_q;
        instr_d    = instr_q;
        acc_d      = acc_q;
        rf_we_d    = 1'b0;
        rf_waddr_d = rf_waddr_q;
        rf_wdata_d = rf_wdata_q;
        done_d     = 1'b0;
        branch_d   = 1'b0;
        tgt_d      = tgt_q;
        ready_c    = 1'b0;
        alu_op_c   = OP_ADD;

        case (state_q)
            IDLE: begin
                ready_c = 1'b1;
                if (bus.instr_valid) begin
                    instr_d = bus.instr;
                    state_d = READ;
                end
            end
            READ: begin
                state_d = EXEC;
            end
            EXEC: begin
                // Everything registered here becomes visible during WB, so the
                // commit pulses line up with done and acc_out updates from WB on.
                alu_op_c = dec_alu_op;
                done_d   = 1'b1;
                state_d  = WB;
                if (!dec_is_misc) begin
                    if (dec_dest_reg) begin
                        rf_we_d    = 1'b1;
                        rf_waddr_d = dec_reg_addr;
                        rf_wdata_d = bus.alu_rslt;
                    end else begin
                        acc_d = bus.alu_rslt;
                    end
                end else begin
                    case (dec_misc_op)
                        MISC_LDA: acc_d = bus.rf_rdata;
                        MISC_STA: begin
                            rf_we_d    = 1'b1;
                            rf_waddr_d = dec_reg_addr;
                            rf_wdata_d = acc_q;
                        end
                        MISC_BNZ: begin
                            branch_d = (acc_q != '0);
                            tgt_d    = dec_imm;
                        end
                        MISC_LDI: acc_d = DW'(dec_imm);
                        default: ;
                    endcase
                end
            end
            WB: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            instr_q    <= '0;
            acc_q      <= '0;
            rf_we_q    <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
            done_q     <= 1'b0;
            branch_q   <= 1'b0;
            tgt_q      <= '0;
        end else begin
            state_q    <= state_d;
            instr_q    <= instr_d;
            acc_q      <= acc_d;
            rf_we_q    <= rf_we_d;
            rf_waddr_q <= rf_waddr_d;
            rf_wdata_q <= rf_wdata_d;
            done_q     <= done_d;
            branch_q   <= branch_d;
            tgt_q      <= tgt_d;
        end
    end

    // The captured address is held from accept through WB; it reads 0 out of reset.
    assign bus.instr_ready = ready_c;
    assign bus.rf_raddr    = dec_reg_addr;
    assign bus.rf_we       = rf_we_q;
    assign bus.rf_waddr    = rf_waddr_q;
    assign bus.rf_wdata    = rf_wdata_q;
    assign bus.alu_op      = alu_op_c;
    assign bus.alu_reg     = bus.rf_rdata;
    assign bus.alu_acc     = acc_q;

    assign acc_out      = acc_q;
    assign done         = done_q;
    assign branch_taken = branch_q;
    assign branch_tgt   = tgt_q;

`ifdef ALU_SEQ_PERF_EN
    logic [PERF_W-1:0] perf_q, perf_d;

    always_comb begin
        perf_d = perf_q;
        if (done_q) perf_d = perf_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) perf_q <= '0;
        else        perf_q <= perf_d;
    end

    assign perf_count = perf_q;
`else
    assign perf_count = '0;
`endif

endmodule
